traffic_light_sequencer: RTL
============================

Name: traffic_light_sequencer

Overview:
Main-road/side-road traffic light FSM. It sequences phases using interval lengths read from the TimeParameters interval store. It drives `interval_address`, captures the returned value into a seconds countdown, and advances phases on expiry. It also latches the side-road sensor and pedestrian walk requests, and restarts the cycle whenever the store is reprogrammed.

Parameters:
VAL_W, 4, width of interval value (seconds)
TICK_DIV, 50_000_000, clk cycles per one-second tick (bench uses 4)

Ports:
clk  in  1  system clock
sys_reset  in  1  synchronous, active-high reset
sensor  in  1  side-road vehicle present (level or pulse)
walk_request  in  1  pedestrian button (pulse)
prg_sync_in  in  1  interval store reprogrammed this cycle; restart sequence
interval_value  in  VAL_W  TimeParameters output_value for current interval_address, valid same cycle
interval_address  out  2  interval select: 00 BASE, 01 EXT, 10 YEL (11 never driven)
main_light  out  3  one-hot {red,yellow,green}
side_light  out  3  one-hot {red,yellow,green}
walk_lamp  out  1  pedestrian walk indicator

Behaviour:
- Clock and reset: one clock, `clk`. Reset `sys_reset` is synchronous and active-high. It has priority over everything else.
- Reset values: state=MAIN_G, main_light=001, side_light=100, walk_lamp=0, interval_address=00, sensor_lat=0, walk_lat=0, remaining=0, tick count=0.
  - The first cycle after reset release is the MAIN_G entry cycle.
- States, with interval address in brackets:
  - MAIN_G [BASE]: main green, side red.
  - MAIN_G2 [EXT if sensor_lat else BASE]: main green.
  - MAIN_Y [YEL]: main yellow.
  - WALK [EXT]: both red, walk_lamp=1.
  - SIDE_G [BASE]: side green.
  - SIDE_G2 [EXT]: side green.
  - SIDE_Y [YEL]: side yellow.
- Transitions on expiry:
  - MAIN_G -> MAIN_G2 -> MAIN_Y.
  - MAIN_Y -> WALK if walk_lat, else SIDE_G.
  - WALK -> SIDE_G; walk_lat cleared on the WALK exit edge.
  - SIDE_G -> SIDE_G2 if sensor_lat, else SIDE_Y.
  - SIDE_G2 -> SIDE_Y; sensor_lat cleared on the SIDE_G2 exit edge.
  - SIDE_Y -> MAIN_G.
- Addressing and lights: interval_address and lights are registered. They update on the same edge as the state change, so both are valid in the entry cycle.
- Timing per state:
  - Entry cycle: remaining <= max(interval_value,1) and the tick divider is cleared.
  - Each subsequent TICK_DIV-th cycle produces one tick, which decrements remaining.
  - The tick taking remaining from 1 causes the transition on that edge.
  - State duration = 1 + max(v,1)*TICK_DIV cycles.
- Request latches:
  - sensor_lat and walk_lat are set on any cycle where the input is 1.
  - If set and clear coincide, set wins: the latch stays 1.
  - Both latches may be pending together; each is serviced at its own decision point.
- prg_sync_in = 1 (without reset):
  - Next state is MAIN_G, taking a new entry cycle with address 00.
  - Divider cleared, latches retained.
  - Applies in any state, including mid-count.
- Mid-count value changes: interval_value changes after the entry cycle are ignored until the next entry.
- Illegal state encoding recovers to MAIN_G.
- Lights invariant: never both roads non-red in the same cycle.

Decomposition:
- Shared package `traffic_pkg`:
  - State enum.
  - Interval address constants ADDR_BASE=2'b00, ADDR_EXT=2'b01, ADDR_YEL=2'b10.
  - Light encodings LIGHT_R=3'b100, LIGHT_Y=3'b010, LIGHT_G=3'b001.
- One sub-module, `tick_divider`:
  - Inputs: clk, sys_reset, clear.
  - Output: 1-cycle tick every TICK_DIV cycles after clear.
- The FSM, latches and countdown stay in the top module.

Test Plan:
Common setup for all scenarios: TICK_DIV=4; bench model returns BASE=6, EXT=3, YEL=2.
- Idle loop, no requests:
  - Durations: MAIN_G 25, MAIN_G2 25, MAIN_Y 9, SIDE_G 25, SIDE_Y 9 cycles, then MAIN_G; addresses 00,00,10,00,10.
  - Lights-invariant assertion holds throughout.
- sensor pulse during MAIN_G:
  - MAIN_G2 uses address 01 and lasts 13 cycles.
  - SIDE_G2 appears for 13 cycles, and sensor_lat=0 after it.
- walk_request pulse during MAIN_G2:
  - After MAIN_Y, WALK runs for 13 cycles with main=side=100 and walk_lamp=1.
  - walk_lat is cleared; the next loop has no WALK.
- interval_value=0 for YEL: MAIN_Y lasts 5 cycles (minimum 1 s).
- prg_sync_in pulse at cycle 10 of SIDE_G: next cycle state=MAIN_G, address 00, full 25-cycle MAIN_G; a pending sensor_lat is still honoured.
- sys_reset asserted mid-WALK for 1 cycle: next cycle all outputs at reset values, latches 0, then MAIN_G lasts 25 cycles.

Source files
------------

// File: rtl/traffic_light_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the main-road/side-road traffic light sequencer:
//   - state_e      : sequencer phase encoding (3 bits, code 3'd7 unused)
//   - ADDR_*       : interval store select codes driven on interval_address
//   - LIGHT_*      : one-hot {red,yellow,green} lamp encodings
//   - phase_out_t  : bundle of everything registered on phase entry
//   - phase_outputs: maps a phase to its interval address and lamp pattern
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_G  = 3'd0,
        ST_MAIN_G2 = 3'd1,
        ST_MAIN_Y  = 3'd2,
        ST_WALK    = 3'd3,
        ST_SIDE_G  = 3'd4,
        ST_SIDE_G2 = 3'd5,
        ST_SIDE_Y  = 3'd6
    } state_e;

    localparam logic [1:0] ADDR_BASE = 2'b00;
    localparam logic [1:0] ADDR_EXT  = 2'b01;
    localparam logic [1:0] ADDR_YEL  = 2'b10;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    typedef struct packed {
        logic [1:0] addr;
        logic [2:0] main_light;
        logic [2:0] side_light;
        logic       walk_lamp;
    } phase_out_t;

    // Every phase keeps at least one road red, so the lamp pattern of any
    // legal state satisfies the "never both roads non-red" invariant.
    // Unknown encodings fall back to the MAIN_G pattern, matching the
    // recovery target of the sequencer.
    function automatic phase_out_t phase_outputs(input state_e st,
                                                 input logic   sensor_pending);
        phase_out_t po;
        po.addr       = ADDR_BASE;
        po.main_light = LIGHT_G;
        po.side_light = LIGHT_R;
        po.walk_lamp  = 1'b0;
        case (st)
            ST_MAIN_G: begin
                po.addr = ADDR_BASE;
            end
            ST_MAIN_G2: begin
                // A waiting side-road vehicle stretches the main green with
                // the extension interval instead of a second base interval.
                po.addr = sensor_pending ? ADDR_EXT : ADDR_BASE;
            end
            ST_MAIN_Y: begin
                po.addr       = ADDR_YEL;
                po.main_light = LIGHT_Y;
            end
            ST_WALK: begin
                po.addr       = ADDR_EXT;
                po.main_light = LIGHT_R;
                po.walk_lamp  = 1'b1;
            end
            ST_SIDE_G: begin
                po.addr       = ADDR_BASE;
                po.main_light = LIGHT_R;
                po.side_light = LIGHT_G;
            end
            ST_SIDE_G2: begin
                po.addr       = ADDR_EXT;
                po.main_light = LIGHT_R;
                po.side_light = LIGHT_G;
            end
            ST_SIDE_Y: begin
                po.addr       = ADDR_YEL;
                po.main_light = LIGHT_R;
                po.side_light = LIGHT_Y;
            end
            default: begin
                po.addr = ADDR_BASE;
            end
        endcase
        return po;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_tick_divider.sv
// ----------------------------------------------------------------------------
// tick_divider
// Free-running one-second tick generator that can be re-phased.
//   clk       : system clock
//   sys_reset : synchronous, active-high reset
//   clear     : restart the count; no tick is produced in a clear cycle
//   tick      : one-cycle pulse on every TICK_DIV-th cycle after clear
// After a clear cycle the counter sits at 0, so the first tick appears in
// the TICK_DIV-th following cycle.
// ----------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_last;

    assign at_last = (count_reg == CNT_LAST);
    assign tick    = at_last & ~clear;

    always_comb begin
        count_next = count_reg + CNT_W'(1);
        if (clear || at_last) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/traffic_light_sequencer.sv
// ----------------------------------------------------------------------------
// traffic_light_sequencer
// Main-road/side-road traffic light controller. Each phase reads its length
// (in seconds) from an external interval store through interval_address,
// counts it down with a one-second tick and then advances.
//   clk              : system clock
//   sys_reset        : synchronous, active-high reset (highest priority)
//   sensor           : side-road vehicle present, latched until serviced
//   walk_request     : pedestrian button, latched until serviced
//   prg_sync_in      : interval store was reprogrammed; restart at MAIN_G
//   interval_value   : store output for the current interval_address
//   interval_address : 00 BASE, 01 EXT, 10 YEL
//   main_light       : one-hot {red,yellow,green} for the main road
//   side_light       : one-hot {red,yellow,green} for the side road
//   walk_lamp        : pedestrian walk indicator
// A phase lasts 1 + max(v,1)*TICK_DIV cycles: one entry cycle in which the
// interval value is captured, then max(v,1) ticks.
// ----------------------------------------------------------------------------
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int VAL_W    = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             sensor,
    input  logic             walk_request,
    input  logic             prg_sync_in,
    input  logic [VAL_W-1:0] interval_value,
    output logic [1:0]       interval_address,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk_lamp
);

    state_e           state_reg;
    state_e           state_next;
    logic             entry_reg;      // current cycle is a phase entry cycle
    logic             entry_next;
    logic [VAL_W-1:0] remaining_reg;  // whole seconds left in this phase
    logic [VAL_W-1:0] remaining_next;
    logic             sensor_lat_reg;
    logic             sensor_lat_next;
    logic             walk_lat_reg;
    logic             walk_lat_next;
    phase_out_t       out_reg;
    phase_out_t       out_next;

    logic             tick;
    logic             tick_clear;
    logic             expire;
    logic             sensor_clr;
    logic             walk_clr;

    // The divider is re-phased on every entry cycle and also in the cycle a
    // reprogram arrives, so a restart never inherits a partial second.
    assign tick_clear = entry_reg | prg_sync_in;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk       (clk),
        .sys_reset (sys_reset),
        .clear     (tick_clear),
        .tick      (tick)
    );

    // The tick that would take remaining from 1 to 0 ends the phase instead.
    // Treating 0 as expired too keeps a corrupted count from stalling.
    assign expire = tick & ~entry_reg & (remaining_reg <= VAL_W'(1));

    // ------------------------------------------------------------------
    // Next-state and phase sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        entry_next = 1'b0;
        sensor_clr = 1'b0;
        walk_clr   = 1'b0;

        if (prg_sync_in) begin
            state_next = ST_MAIN_G;
            entry_next = 1'b1;
        end else begin
            case (state_reg)
                ST_MAIN_G: begin
                    if (expire) state_next = ST_MAIN_G2;
                end
                ST_MAIN_G2: begin
                    if (expire) state_next = ST_MAIN_Y;
                end
                ST_MAIN_Y: begin
                    if (expire) state_next = walk_lat_reg ? ST_WALK : ST_SIDE_G;
                end
                ST_WALK: begin
                    if (expire) begin
                        state_next = ST_SIDE_G;
                        walk_clr   = 1'b1;
                    end
                end
                ST_SIDE_G: begin
                    if (expire) state_next = sensor_lat_reg ? ST_SIDE_G2 : ST_SIDE_Y;
                end
                ST_SIDE_G2: begin
                    if (expire) begin
                        state_next = ST_SIDE_Y;
                        sensor_clr = 1'b1;
                    end
                end
                ST_SIDE_Y: begin
                    if (expire) state_next = ST_MAIN_G;
                end
                default: begin
                    // Unused encoding: restart the cycle cleanly.
                    state_next = ST_MAIN_G;
                    entry_next = 1'b1;
                end
            endcase
            if (expire) begin
                entry_next = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Countdown, request latches and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        remaining_next = remaining_reg;
        if (entry_reg) begin
            // A zero-length interval is stretched to one second.
            remaining_next = (interval_value == '0) ? VAL_W'(1) : interval_value;
        end else if (tick && (remaining_reg != '0)) begin
            remaining_next = remaining_reg - VAL_W'(1);
        end
    end

    // A new request in the same cycle as the service point wins, so a
    // request arriving exactly at the exit edge is not lost.
    assign sensor_lat_next = sensor       | (sensor_lat_reg & ~sensor_clr);
    assign walk_lat_next   = walk_request | (walk_lat_reg   & ~walk_clr);

    // Address and lamps change only when a phase is entered, so a request
    // latched mid-phase cannot retarget the address of a running phase.
    always_comb begin
        out_next = out_reg;
        if (entry_next) begin
            out_next = phase_outputs(state_next, sensor_lat_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_reg      <= ST_MAIN_G;
            entry_reg      <= 1'b1;
            remaining_reg  <= '0;
            sensor_lat_reg <= 1'b0;
            walk_lat_reg   <= 1'b0;
            out_reg        <= phase_outputs(ST_MAIN_G, 1'b0);
        end else begin
            state_reg      <= state_next;
            entry_reg      <= entry_next;
            remaining_reg  <= remaining_next;
            sensor_lat_reg <= sensor_lat_next;
            walk_lat_reg   <= walk_lat_next;
            out_reg        <= out_next;
        end
    end

    assign interval_address = out_reg.addr;
    assign main_light       = out_reg.main_light;
    assign side_light       = out_reg.side_light;
    assign walk_lamp        = out_reg.walk_lamp;

endmodule
